// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: one conflict-free FSM drives the road A (main) and road B (side) light codes.
// Latency: lights and phase decode combinationally from the state register; a b_sense/ped_req press is latched on the next clk edge.
// Backpressure: none; b_sense and ped_req are latched into sticky requests, so a short pulse is never lost.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   b_sense  in   road-B vehicle detector (level or pulse)
//   a_light  out  road-A code: 00 red, 01 yellow, 10 green
//   b_light  out  road-B code, same encoding (11 is never driven)
//   phase    out  current state code, for debug and monitoring
//   ped_req  in   pedestrian push-button      (only with PED_WALK_EN)
//   walk     out  pedestrian walk lamp        (only with PED_WALK_EN)
//
// Optional feature macro: PED_WALK_EN adds the pedestrian walk interval (WALK_ST).
// Without it the ped ports and WALK_ST do not exist, WALK is ignored and phase never reads 6.

module traffic_phase_ctrl #(
    parameter int CNT_W       = 8,
    parameter int ALL_RED     = 2,
    parameter int A_GREEN_MIN = 20,
    parameter int YELLOW      = 4,
    parameter int B_GREEN     = 15,
    parameter int WALK        = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b_sense,
`ifdef PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [1:0] a_light,
    output logic [1:0] b_light,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        AR_TO_A = 3'd0,
        A_GRN   = 3'd1,
        A_YEL   = 3'd2,
        AR_TO_B = 3'd3,
        B_GRN   = 3'd4,
        B_YEL   = 3'd5
`ifdef PED_WALK_EN
        ,
        WALK_ST = 3'd6
`endif
    } state_t;

    localparam logic [1:0] LT_RED = 2'b00;
    localparam logic [1:0] LT_YEL = 2'b01;
    localparam logic [1:0] LT_GRN = 2'b10;

    // A timed state of N cycles leaves on the edge where cnt == N-1.
    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] BGRN_LAST  = CNT_W'(B_GREEN - 1);
    localparam logic [CNT_W-1:0] AMIN_LAST  = CNT_W'(A_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             b_req_q;
    logic             enter_bgrn;

`ifdef PED_WALK_EN
    logic             ped_q;
    logic             ped_dest_b;   // green to enter after WALK_ST: 1 = B_GRN, 0 = A_GRN
    logic             enter_walk;
`else
    // WALK has no meaning without the walk interval; keep it referenced.
    logic [CNT_W-1:0] unused_walk;
    assign unused_walk = WALK_LAST;
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            AR_TO_A: begin
                if (cnt == AR_LAST) begin
`ifdef PED_WALK_EN
                    if (ped_q) state_nxt = WALK_ST;
                    else       state_nxt = A_GRN;
`else
                    state_nxt = A_GRN;
`endif
                end
            end
            // A rests green until a latched B request arrives after the minimum green.
            A_GRN:   if (b_req_q && (cnt >= AMIN_LAST)) state_nxt = A_YEL;
            A_YEL:   if (cnt == YEL_LAST) state_nxt = AR_TO_B;
            AR_TO_B: begin
                if (cnt == AR_LAST) begin
`ifdef PED_WALK_EN
                    if (ped_q) state_nxt = WALK_ST;
                    else       state_nxt = B_GRN;
`else
                    state_nxt = B_GRN;
`endif
                end
            end
            B_GRN:   if (cnt == BGRN_LAST) state_nxt = B_YEL;
            B_YEL:   if (cnt == YEL_LAST) state_nxt = AR_TO_A;
`ifdef PED_WALK_EN
            WALK_ST: if (cnt == WALK_LAST) state_nxt = ped_dest_b ? B_GRN : A_GRN;
`endif
            default: state_nxt = AR_TO_A;
        endcase
    end

    assign enter_bgrn = (state_nxt == B_GRN) && (state != B_GRN);
`ifdef PED_WALK_EN
    assign enter_walk = (state_nxt == WALK_ST) && (state != WALK_ST);
`endif

    // State and phase-duration counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= AR_TO_A;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) cnt <= '0;
            else if (cnt != '1)     cnt <= cnt + 1'b1;
        end
    end

    // Sticky B request; the clear on B_GRN entry wins over a simultaneous b_sense,
    // so a press on that very edge counts as served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           b_req_q <= 1'b0;
        else if (enter_bgrn) b_req_q <= 1'b0;
        else if (b_sense)    b_req_q <= 1'b1;
    end

`ifdef PED_WALK_EN
    // Sticky ped request and the green to resume after the walk interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_q      <= 1'b0;
            ped_dest_b <= 1'b0;
        end else begin
            if (enter_walk)   ped_q <= 1'b0;
            else if (ped_req) ped_q <= 1'b1;
            if (enter_walk)   ped_dest_b <= (state == AR_TO_B);
        end
    end
`endif

    // Light decode straight from the state register: at most one road non-red.
    always_comb begin
        a_light = LT_RED;
        b_light = LT_RED;
        case (state)
            A_GRN:   a_light = LT_GRN;
            A_YEL:   a_light = LT_YEL;
            B_GRN:   b_light = LT_GRN;
            B_YEL:   b_light = LT_YEL;
            default: ;
        endcase
    end

    assign phase = state;
`ifdef PED_WALK_EN
    assign walk  = (state == WALK_ST);
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with ALL_RED=2, A_GREEN_MIN=5, YELLOW=3, B_GREEN=4, WALK=3.
// Every cycle is checked against the expected phase and the lights implied by that phase.
// A background monitor checks, each negedge, that both roads are never non-red together.

module tb_traffic_phase_ctrl;

    logic       clk;
    logic       reset;
    logic       b_sense;
    logic [1:0] a_light;
    logic [1:0] b_light;
    logic [2:0] phase;
`ifdef PED_WALK_EN
    logic       ped_req;
    logic       walk;
`endif

    int checks   = 0;
    int failures = 0;
    bit done     = 0;

    traffic_phase_ctrl #(
        .CNT_W(8), .ALL_RED(2), .A_GREEN_MIN(5), .YELLOW(3), .B_GREEN(4), .WALK(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .b_sense (b_sense),
`ifdef PED_WALK_EN
        .ped_req (ped_req),
        .walk    (walk),
`endif
        .a_light (a_light),
        .b_light (b_light),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_a(input logic [2:0] ph);
        return (ph == 3'd1) ? 2'b10 : (ph == 3'd2) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [1:0] exp_b(input logic [2:0] ph);
        return (ph == 3'd4) ? 2'b10 : (ph == 3'd5) ? 2'b01 : 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check that the DUT sits in phase ph for n consecutive cycles, starting now.
    task automatic expect_phase(input string tag, input logic [2:0] ph, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_phase"}, {5'd0, phase}, {5'd0, ph});
            chk({tag, "_a"}, {6'd0, a_light}, {6'd0, exp_a(ph)});
            chk({tag, "_b"}, {6'd0, b_light}, {6'd0, exp_b(ph)});
`ifdef PED_WALK_EN
            chk({tag, "_walk"}, {7'd0, walk}, {7'd0, (ph == 3'd6)});
`endif
            tick();
        end
    endtask

    // One B service starting at A_YEL, ending at the first A_GRN cycle.
    task automatic expect_service(input string tag);
        expect_phase({tag, "_ayel"}, 3'd2, 3);
        expect_phase({tag, "_ar2b"}, 3'd3, 2);
        expect_phase({tag, "_bgrn"}, 3'd4, 4);
        expect_phase({tag, "_byel"}, 3'd5, 3);
        expect_phase({tag, "_ar2a"}, 3'd0, 2);
    endtask

    always @(negedge clk) begin
        if (!done) begin
            chk("mon_conflict", {7'd0, (a_light != 2'b00) && (b_light != 2'b00)}, 8'd0);
`ifndef PED_WALK_EN
            chk("mon_no_walk_phase", {7'd0, (phase == 3'd6)}, 8'd0);
`endif
        end
    end

    initial begin
        reset   = 1'b1;
        b_sense = 1'b0;
`ifdef PED_WALK_EN
        ped_req = 1'b0;
`endif
        // Reset held 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase", {5'd0, phase}, 8'd0);
        chk("rst_a", {6'd0, a_light}, 8'd0);
        chk("rst_b", {6'd0, b_light}, 8'd0);
        reset = 1'b0;

        // Both red for 2 cycles, then A rests green with no request (counter saturates).
        expect_phase("boot_ar", 3'd0, 2);
        expect_phase("rest_agrn", 3'd1, 299);

        // Pulse b_sense while saturated: latched on this edge, A_YEL on the next.
        b_sense = 1'b1;
        expect_phase("sat_pulse", 3'd1, 1);
        b_sense = 1'b0;
        expect_phase("sat_last", 3'd1, 1);
        expect_service("svc_sat");

        // Pulse at A_GRN cnt=1: A green lasts exactly the 5-cycle minimum.
        expect_phase("min_c0", 3'd1, 1);
        b_sense = 1'b1;
        expect_phase("min_c1", 3'd1, 1);
        b_sense = 1'b0;
        expect_phase("min_c2", 3'd1, 3);
        expect_service("svc_min");

        // Pulse at A_GRN cnt=30: latched, then A_YEL on the following edge.
        expect_phase("c30_pre", 3'd1, 30);
        b_sense = 1'b1;
        expect_phase("c30_pulse", 3'd1, 1);
        b_sense = 1'b0;
        expect_phase("c30_last", 3'd1, 1);
        expect_service("svc_c30");

        // b_sense held high: 19-cycle period repeats.
        b_sense = 1'b1;
        for (int p = 0; p < 2; p++) begin
            expect_phase("hold_agrn", 3'd1, 5);
            expect_service("svc_hold");
        end

        // Request still pending from the B phases; b_sense high only on the B_GRN
        // entry edge is served by that entry, so A rests afterwards.
        b_sense = 1'b0;
        expect_phase("t5_agrn", 3'd1, 5);
        expect_phase("t5_ayel", 3'd2, 3);
        expect_phase("t5_ar2b", 3'd3, 1);
        b_sense = 1'b1;
        expect_phase("t5_entry", 3'd3, 1);
        b_sense = 1'b0;
        expect_phase("t5_bgrn", 3'd4, 4);
        expect_phase("t5_byel", 3'd5, 3);
        expect_phase("t5_ar2a", 3'd0, 2);
        expect_phase("t5_rest", 3'd1, 40);

        // Reset mid-B_GRN with a fresh request latched.
        b_sense = 1'b1;
        expect_phase("t4_req", 3'd1, 1);
        b_sense = 1'b0;
        expect_phase("t4_last", 3'd1, 1);
        expect_phase("t4_ayel", 3'd2, 3);
        expect_phase("t4_ar2b", 3'd3, 2);
        expect_phase("t4_bgrn", 3'd4, 2);
        b_sense = 1'b1;
        expect_phase("t4_bgrn_req", 3'd4, 1);
        b_sense = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t4_async_b", {6'd0, b_light}, 8'd0);
        chk("t4_async_phase", {5'd0, phase}, 8'd0);
        chk("t4_async_a", {6'd0, a_light}, 8'd0);
        #2;
        reset = 1'b0;
        expect_phase("t4_boot_ar", 3'd0, 2);
        expect_phase("t4_rest", 3'd1, 30);

`ifdef PED_WALK_EN
        // Ped press with a B request pending: walk interval inserted before B_GRN.
        b_sense = 1'b1;
        ped_req = 1'b1;
        expect_phase("t6_req", 3'd1, 1);
        b_sense = 1'b0;
        ped_req = 1'b0;
        expect_phase("t6_last", 3'd1, 1);
        expect_phase("t6_ayel", 3'd2, 3);
        expect_phase("t6_ar2b", 3'd3, 2);
        expect_phase("t6_walk", 3'd6, 3);
        expect_phase("t6_bgrn", 3'd4, 4);
        expect_phase("t6_byel", 3'd5, 3);
        expect_phase("t6_ar2a", 3'd0, 2);
        expect_phase("t6_rest", 3'd1, 10);
`endif

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
